// File: rtl/dm_scroll_feeder_pkg.sv
// dm_pkg: shared constants for the 8x8 dot-matrix scroll feeder.
//   - DM_ROWS / DM_COLS / DM_IDX_W : matrix geometry and glyph/column index width
//   - DM_BLANK                     : all pixels off (active-low, so all ones)
//   - GLYPH_*                      : 8 glyphs, active-low, row r = bits [63-8r -: 8],
//                                    bit 7 of each row byte is the leftmost column
//   - dm_glyph()                   : glyph lookup by 3-bit index
package dm_pkg;

  localparam int DM_ROWS  = 8;
  localparam int DM_COLS  = 8;
  localparam int DM_IDX_W = 3;

  localparam logic [63:0] DM_BLANK = {64{1'b1}};

  localparam logic [63:0] GLYPH_HEART   = 64'hFF99_0000_81C3_E7FF;
  localparam logic [63:0] GLYPH_SMILE   = 64'hC3BD_5A7E_5A66_BDC3;
  localparam logic [63:0] GLYPH_ARROW   = 64'hE7F3_0100_01F3_E7FF;
  localparam logic [63:0] GLYPH_HOME    = 64'hE7C3_8100_BDA5_A581;
  localparam logic [63:0] GLYPH_DIAMOND = 64'hE7C3_8100_0081_C3E7;
  localparam logic [63:0] GLYPH_CROSS   = 64'hE7E7_E700_00E7_E7E7;
  localparam logic [63:0] GLYPH_CHECK   = 64'hFFFE_FCF9_7327_8FDF;
  localparam logic [63:0] GLYPH_BOX     = 64'h007E_7E7E_7E7E_7E00;

  function automatic logic [63:0] dm_glyph(input logic [DM_IDX_W-1:0] idx);
    logic [63:0] g;
    case (idx)
      3'd0:    g = GLYPH_HEART;
      3'd1:    g = GLYPH_SMILE;
      3'd2:    g = GLYPH_ARROW;
      3'd3:    g = GLYPH_HOME;
      3'd4:    g = GLYPH_DIAMOND;
      3'd5:    g = GLYPH_CROSS;
      3'd6:    g = GLYPH_CHECK;
      default: g = GLYPH_BOX;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dm_scroll_feeder_if.sv
// dm_scroll_feeder_if: control/status bundle between the top-level controller,
// the scanner and the scroll feeder.
//   i_En, i_Clr, i_fDone : controls into the feeder
//   o_Data, o_Step, o_Wrap : frame and status pulses out of the feeder
//   o_DbgFrm/o_DbgCol/o_DbgGly : live counter values for observation
// Signalling: there is no valid/ready handshake. i_fDone is an event strobe,
// every cycle it is high (while i_En) counts as one completed frame; o_Step and
// o_Wrap are single-cycle strobes; o_Data is a level that only changes on a step.
interface dm_scroll_feeder_if;
  logic        i_En;
  logic        i_Clr;
  logic        i_fDone;
  logic [63:0] o_Data;
  logic        o_Step;
  logic        o_Wrap;
  logic [31:0] o_DbgFrm;
  logic [2:0]  o_DbgCol;
  logic [2:0]  o_DbgGly;

  modport master (
    output i_En, i_Clr, i_fDone,
    input  o_Data, o_Step, o_Wrap, o_DbgFrm, o_DbgCol, o_DbgGly
  );

  modport slave (
    input  i_En, i_Clr, i_fDone,
    output o_Data, o_Step, o_Wrap, o_DbgFrm, o_DbgCol, o_DbgGly
  );
endinterface

// File: rtl/dm_scroll_feeder_glyph_rom.sv
// dm_glyph_rom: combinational column fetch from the glyph ROM.
//   i_Gly     : glyph index 0..7
//   i_Col     : column index 0..7 (0 = leftmost)
//   o_ColBits : bit r = pixel of row r in that column (active-low)
module dm_glyph_rom
  import dm_pkg::*;
(
  input  logic [2:0] i_Gly,
  input  logic [2:0] i_Col,
  output logic [7:0] o_ColBits
);

  logic [63:0] w_Glyph;
  assign w_Glyph = dm_glyph(i_Gly);

  for (genvar r = 0; r < DM_ROWS; r++) begin : g_row
    logic [7:0] w_Row;
    assign w_Row        = w_Glyph[63-8*r -: 8];
    // Column 0 lives in bit 7 of the row byte.
    assign o_ColBits[r] = w_Row[3'd7 - i_Col];
  end

endmodule

// File: rtl/dm_scroll_feeder.sv
// dm_scroll_feeder: scrolls a circular message of NUM_GLYPHS glyphs (ROM
// indices 0..NUM_GLYPHS-1) leftwards across an 8x8 matrix, one column per
// STEP_FRAMES frame-done events.
//   i_Clk, i_Rst : clock and asynchronous active-high reset
//   bus.i_En     : enable; low freezes all state and ignores i_fDone
//   bus.i_Clr    : synchronous clear to blank window, counters 0 (beats a step)
//   bus.i_fDone  : one event per cycle high
//   bus.o_Data   : registered 64-bit frame, active-low
//   bus.o_Step   : pulse, window shifted this cycle
//   bus.o_Wrap   : pulse, last column of last glyph inserted this cycle
//   bus.o_Dbg*   : frame / column / glyph counters
module dm_scroll_feeder
  import dm_pkg::*;
#(
  parameter int NUM_GLYPHS  = 4,
  parameter int STEP_FRAMES = 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  dm_scroll_feeder_if.slave  bus
);

  localparam int FRM_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int GLY_W = (NUM_GLYPHS  > 1) ? $clog2(NUM_GLYPHS)  : 1;

  logic [63:0]      r_Win;
  logic [FRM_W-1:0] r_Frm;
  logic [2:0]       r_Col;
  logic [GLY_W-1:0] r_Gly;
  logic             r_Step;
  logic             r_Wrap;

  logic        w_FrmLast;
  logic        w_ColLast;
  logic        w_GlyLast;
  logic        w_Step;
  logic [7:0]  w_ColBits;
  logic [63:0] w_NextWin;

  // Compare at 32 bits so a narrow counter never aliases a larger limit.
  assign w_FrmLast = (32'(r_Frm) == 32'(STEP_FRAMES - 1));
  assign w_GlyLast = (32'(r_Gly) == 32'(NUM_GLYPHS - 1));
  assign w_ColLast = (r_Col == 3'd7);
  assign w_Step    = bus.i_En & bus.i_fDone & w_FrmLast;

  dm_glyph_rom u_rom (
    .i_Gly     (3'(r_Gly)),
    .i_Col     (r_Col),
    .o_ColBits (w_ColBits)
  );

  // Each row shifts left; the fetched column enters at bit 0 (rightmost).
  for (genvar r = 0; r < DM_ROWS; r++) begin : g_shift
    assign w_NextWin[63-8*r -: 8] = {r_Win[62-8*r -: 7], w_ColBits[r]};
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Win  <= DM_BLANK;
      r_Frm  <= '0;
      r_Col  <= '0;
      r_Gly  <= '0;
      r_Step <= 1'b0;
      r_Wrap <= 1'b0;
    end else begin
      r_Step <= 1'b0;
      r_Wrap <= 1'b0;
      if (bus.i_Clr) begin
        r_Win <= DM_BLANK;
        r_Frm <= '0;
        r_Col <= '0;
        r_Gly <= '0;
      end else if (w_Step) begin
        r_Win  <= w_NextWin;
        r_Frm  <= '0;
        r_Col  <= r_Col + 3'd1;
        if (w_ColLast) begin
          r_Gly <= w_GlyLast ? '0 : r_Gly + 1'b1;
        end
        r_Step <= 1'b1;
        r_Wrap <= w_ColLast & w_GlyLast;
      end else if (bus.i_En & bus.i_fDone) begin
        r_Frm <= r_Frm + 1'b1;
      end
    end
  end

  assign bus.o_Data   = r_Win;
  assign bus.o_Step   = r_Step;
  assign bus.o_Wrap   = r_Wrap;
  assign bus.o_DbgFrm = 32'(r_Frm);
  assign bus.o_DbgCol = r_Col;
  assign bus.o_DbgGly = 3'(r_Gly);

endmodule

// File: doc/dm_scroll_feeder.md
# dm_scroll_feeder

Frame-source stage feeding the 8x8 dot-matrix scanner's 64-bit frame input. Scrolls a circular message of 8x8 glyphs from a shared glyph ROM across the matrix one column at a time. Advances by one column each time the scanner reports a configurable number of completed frames. Provides step and wrap status pulses to the top-level controller.

## Interface
- NUM_GLYPHS, 4, glyphs in the message, 2..8, taken in order from ROM index 0.
- STEP_FRAMES, 1, scanner frame-done pulses per one-column scroll step, ≥1.
- i_Clk  in  1  system clock (50 MHz)
- i_Rst  in  1  reset, asynchronous, active-high; clock i_Clk
- i_En  in  1  scroll enable. Low freezes the frame counter and window.
- i_Clr  in  1  synchronous clear of window and counters
- i_fDone  in  1  frame-done pulse from scanner, one cycle per completed frame
- o_Data  out  64  frame to scanner, active-low pixels (0 = lit)
- o_Step  out  1  one-cycle pulse, window shifted this cycle
- o_Wrap  out  1  one-cycle pulse, last column of last glyph inserted this cycle

## Operation
- Pixel layout: row r (0 = top) is o_Data[63-8r -: 8]. Bit 7 of each row byte is the leftmost column. The glyph ROM uses the same layout.
- State:
  - 64-bit window register.
  - Frame counter c_Frm, 0..STEP_FRAMES-1.
  - Column index c_Col, 0..7.
  - Glyph index c_Gly, 0..NUM_GLYPHS-1.
- Step condition: i_En & i_fDone & (c_Frm == STEP_FRAMES-1).
  - Non-step cycle with i_En & i_fDone: c_Frm increments.
  - i_En low: all state holds, and i_fDone is ignored.
- On a step:
  - Every row shifts left by one.
  - The new bit 0 of row r is ROM[c_Gly] row r bit (7-c_Col).
  - c_Frm clears to 0.
  - c_Col increments. On 7→0 it carries into c_Gly, which wraps from NUM_GLYPHS-1 to 0.
- o_Step is asserted on every step.
- o_Wrap is asserted on the step where c_Gly == NUM_GLYPHS-1 and c_Col == 7.
- The message is circular. After wrap, glyph 0 follows directly, with no blank gap.
- i_Clr:
  - Window goes to all ones (blank), and all counters go to 0.
  - o_Step and o_Wrap stay 0 that cycle.
  - i_Clr has priority over a coincident step.
- Reset values:
  - o_Data = 64'hFFFF_FFFF_FFFF_FFFF.
  - o_Step = 0, o_Wrap = 0.
  - c_Frm = c_Col = c_Gly = 0.
- Reset mid-scroll returns all state to reset values immediately. No partial step completes.
- Counter widths: $clog2 of each range, minimum 1 bit. Comparisons are done at full width, with no truncation.

## Timing
- All outputs are registered.
- A step sampled at edge k shows the new o_Data, o_Step and o_Wrap after edge k. o_Step and o_Wrap drop after edge k+1 unless another step occurs.
- o_Data is stable between steps, so the scanner always sees a whole frame.
- Each cycle of i_fDone high counts once. If i_fDone is held high, one event is counted per cycle; this is not filtered.
- From reset, glyph 0 is fully on screen after exactly 8·STEP_FRAMES counted frame-done pulses.
- A full message cycle takes 8·NUM_GLYPHS·STEP_FRAMES pulses.

## Structure
- Package dm_pkg holds:
  - Glyph ROM contents (8 × 64-bit constants, index 0..7, incl. HEART/SMILE/ARROW/HOME).
  - DM_BLANK = all ones.
  - Row/column width constants.
- Sub-module dm_glyph_rom is combinational. Inputs are glyph index (3 bits) and column index (3 bits); output is an 8-bit column vector, bit r = row r.
- The top level holds the counters, the window shifter and the pulse logic.

## Test plan
- Reset, then NUM_GLYPHS=2, STEP_FRAMES=1, i_En=1, 8 i_fDone pulses. Required:
  - o_Data==FFFF…FF until the first pulse.
  - o_Step pulses 8 times.
  - After the 8th pulse, o_Data == dm_pkg glyph 0.
  - o_Wrap stays 0.
- Continue with 8 more pulses. Required:
  - o_Data == glyph 1.
  - o_Wrap pulses exactly on the 16th step, coincident with o_Step.
  - The 17th step inserts glyph 0 column 0 at bit 0 of each row.
- STEP_FRAMES=3, pulses at cycles 10, 20, 30. Required:
  - o_Data unchanged after pulses 1 and 2.
  - Shift and o_Step one cycle after the cycle-30 sample.
  - c_Frm back to 0.
- i_En=0 during 5 pulses, then i_En=1. Required:
  - No shift and no o_Step while disabled.
  - The next STEP_FRAMES pulses produce exactly one step.
- i_Clr asserted in the same cycle as a step-qualifying i_fDone, mid-glyph (c_Col=4). Required:
  - o_Data = blank, o_Step = 0.
  - The next 8 steps rebuild glyph 0 from column 0.
- Assert i_Rst asynchronously mid-cycle after 11 steps. Required:
  - o_Data goes to all ones with no clock edge.
  - o_Step = o_Wrap = 0.
  - After release, scrolling restarts from glyph 0 column 0.
